frac_clk_gen: RTL and testbench
===============================

FRAC_CLK_GEN -- requirements
Module: frac_clk_gen

Interface
REQ-001 SHALL provide parameter CHANNELS, default 2, meaning the number of independent output channels (range 1..4).
REQ-002 SHALL provide parameter ACC_W, default 16, meaning the phase-accumulator width in bits (range 4..32).
REQ-003 SHALL provide parameter INIT_INC, default {CHANNELS{16'h0000}}, meaning the packed per-channel increment loaded at reset, with channel 0 in the LSBs.
REQ-004 SHALL provide parameter SETTLE_CYCLES, default 16, meaning the number of clkin cycles lock stays low after reset or after a configuration is applied (>=1).
REQ-005 SHALL provide port clkin, input, width 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL provide port resetn, input, width 1, an asynchronous active-low reset.
REQ-007 SHALL provide port cfg_valid, input, width 1, marking a configuration request.
REQ-008 SHALL provide port cfg_ready, output, width 1, meaning the block can accept a request.
REQ-009 SHALL provide port cfg_chan, input, width max(1,$clog2(CHANNELS)), selecting the target channel.
REQ-010 SHALL provide port cfg_inc, input, width ACC_W, carrying the new increment.
REQ-011 SHALL provide port ce_out, output, width CHANNELS, carrying one-cycle clock-enable pulses per channel.
REQ-012 SHALL provide port clk_out, output, width CHANNELS, carrying the registered square-wave output per channel.
REQ-013 SHALL provide port lock, output, width 1, meaning all channels are running their current configuration and have settled.

Function
REQ-014 SHALL update each channel every clkin cycle as acc <= (acc + inc) mod 2^ACC_W, computing the sum at ACC_W+1 bits.
REQ-015 SHALL register each channel's carry (bit ACC_W of the sum) into ce_out[ch], giving one-cycle pulses at average rate f_clkin*inc/2^ACC_W with latency of 1 cycle after the overflowing add.
REQ-016 SHALL drive clk_out[ch] directly from acc[ACC_W-1] (a register output, not combinational logic).
REQ-017 SHALL treat inc==0 as a disabled channel: acc holds at 0 and ce_out[ch]=0, clk_out[ch]=0.
REQ-018 SHALL produce inc==2^(ACC_W-1) as a pulse every 2 cycles; inc==2^ACC_W-1 SHALL pulse on 2^ACC_W-1 of every 2^ACC_W cycles.
REQ-019 SHALL accept a configuration on a clkin edge where cfg_valid && cfg_ready, holding it in a single pending slot (chan, inc); cfg_ready = !pending.
REQ-020 SHALL ignore requests with cfg_chan >= CHANNELS: they are accepted, dropped and do not affect lock.
REQ-021 SHALL apply a pending update to an enabled channel only on a cycle where that channel's add produces a carry: the new inc is used from the next add and acc keeps its wrapped value, giving a glitch-free changeover.
REQ-022 SHALL apply a pending update to a disabled channel (current inc==0) on the cycle after acceptance, with acc starting from 0.
REQ-023 SHALL apply a pending update with new inc==0 at the next carry boundary, then clear acc to 0.
REQ-024 SHALL clear pending on the application cycle, so cfg_ready returns high the following cycle.
REQ-025 SHALL let pending and the accumulators run independently: other channels are never stalled.
REQ-026 SHALL drop lock to 0 on the cycle after acceptance and hold it low while pending.
REQ-027 SHALL, on application, reload a settle counter to SETTLE_CYCLES and raise lock after it has counted down to 0.
REQ-028 SHALL, when a new update is applied while the counter is running, reload the counter.

Reset
REQ-029 SHALL, while resetn=0, set acc=0, inc=INIT_INC, pending=0, ce_out=0, clk_out=0, lock=0 and cfg_ready=1.
REQ-030 SHALL, after resetn deasserts, load the settle counter with SETTLE_CYCLES; lock rises SETTLE_CYCLES cycles later.
REQ-031 SHALL discard a pending request on reset assertion mid-operation; no partial update is retained.

Verification
REQ-032 SHALL cover: ACC_W=8, INIT_INC ch0=64 -> acc 64,128,192,0; ce_out[0] high 1 cycle in 4, first after the 4th edge post-reset; clk_out[0] 50% duty, period 4.
REQ-033 SHALL cover: ACC_W=8, ch0 inc=96 -> exactly 3 ce pulses per 8 cycles over 256 cycles (96 pulses total).
REQ-034 SHALL cover: ch0 inc=64, request ch0 inc=128 mid-period -> cfg_ready low until the next carry; thereafter pulses every 2 cycles; no pulse gap >4 or <2 cycles at the boundary.
REQ-035 SHALL cover: ch1 disabled (inc=0), request inc=32 -> applied next cycle; first ce_out[1] pulse 8 cycles later; lock low then high SETTLE_CYCLES after application.
REQ-036 SHALL cover: a request with cfg_chan=3 on CHANNELS=2 -> dropped; outputs and lock unchanged.
REQ-037 SHALL cover: resetn pulsed low while a request is pending -> all outputs 0, cfg_ready=1, old INIT_INC rates resume, lock after SETTLE_CYCLES.

Source files
------------

// File: rtl/frac_clk_gen.sv
// Fractional clock generator: one phase accumulator per channel produces
// clock-enable pulses and a square wave at f_clkin * inc / 2^ACC_W.
// Increments are reconfigured through a single-slot request port and only
// switch over at a carry boundary so the outputs never glitch.
module frac_clk_gen #(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned ACC_W         = 16,
    // Packed per-channel reset increment, channel 0 in the LSBs (all zero by default)
    parameter logic [CHANNELS*ACC_W-1:0] INIT_INC = '0,
    parameter int unsigned SETTLE_CYCLES = 16,
    localparam int unsigned ChanW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clkin,
    input  logic                resetn,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [ChanW-1:0]    cfg_chan,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic [CHANNELS-1:0] ce_out,
    output logic [CHANNELS-1:0] clk_out,
    output logic                lock
);

    localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

    logic [ACC_W-1:0]    acc_q [CHANNELS];
    logic [ACC_W-1:0]    acc_d [CHANNELS];
    logic [ACC_W-1:0]    inc_q [CHANNELS];
    logic [ACC_W-1:0]    inc_d [CHANNELS];
    logic [ACC_W:0]      sum   [CHANNELS];
    logic [CHANNELS-1:0] ce_q, ce_d;

    logic                pend_q, pend_d;
    logic [ChanW-1:0]    pend_chan_q, pend_chan_d;
    logic [ACC_W-1:0]    pend_inc_q, pend_inc_d;

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                lock_q, lock_d;
    logic                apply;
    logic                chan_ok;

    // Out-of-range channel requests are accepted but never enter the slot.
    assign chan_ok = 32'(cfg_chan) < CHANNELS;

    // Accumulator advance, carry-aligned changeover, request slot and settle timer.
    always_comb begin
        apply       = 1'b0;
        ce_d        = '0;
        pend_d      = pend_q;
        pend_chan_d = pend_chan_q;
        pend_inc_d  = pend_inc_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            sum[ch]   = {1'b0, acc_q[ch]} + {1'b0, inc_q[ch]};
            acc_d[ch] = sum[ch][ACC_W-1:0];
            inc_d[ch] = inc_q[ch];
            ce_d[ch]  = sum[ch][ACC_W];
            if (pend_q && (32'(pend_chan_q) == ch)) begin
                // A disabled channel switches at once; a running one waits for its carry
                // so the new rate starts from the wrapped phase without a glitch.
                if (inc_q[ch] == '0 || sum[ch][ACC_W]) begin
                    apply     = 1'b1;
                    inc_d[ch] = pend_inc_q;
                    if (pend_inc_q == '0) begin
                        acc_d[ch] = '0;
                    end
                end
            end
        end

        if (apply) begin
            pend_d = 1'b0;
        end else if (cfg_valid && !pend_q && chan_ok) begin
            pend_d      = 1'b1;
            pend_chan_d = cfg_chan;
            pend_inc_d  = cfg_inc;
        end

        cnt_d = cnt_q;
        if (apply) begin
            cnt_d = CntW'(SETTLE_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end

        lock_d = (cnt_d == '0) && !pend_d;
    end

    // State registers; reset discards any pending request and restarts the settle timer.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc_q[ch] <= '0;
                inc_q[ch] <= INIT_INC[ch*ACC_W +: ACC_W];
            end
            ce_q        <= '0;
            pend_q      <= 1'b0;
            pend_chan_q <= '0;
            pend_inc_q  <= '0;
            cnt_q       <= CntW'(SETTLE_CYCLES);
            lock_q      <= 1'b0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                acc_q[ch] <= acc_d[ch];
                inc_q[ch] <= inc_d[ch];
            end
            ce_q        <= ce_d;
            pend_q      <= pend_d;
            pend_chan_q <= pend_chan_d;
            pend_inc_q  <= pend_inc_d;
            cnt_q       <= cnt_d;
            lock_q      <= lock_d;
        end
    end

    // Square wave is the accumulator MSB, straight from the register.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            clk_out[ch] = acc_q[ch][ACC_W-1];
        end
    end

    assign ce_out    = ce_q;
    assign cfg_ready = !pend_q;
    assign lock      = lock_q;

endmodule

// File: tb/tb_frac_clk_gen.sv
// Bench for frac_clk_gen: 3 channels, 8-bit accumulators, INIT ch0=64 ch1=0 ch2=37.
// A phase/edge-count reference model is stepped once per rising edge.
module tb_frac_clk_gen;

    localparam int CH  = 3;
    localparam int AW  = 8;
    localparam int S   = 6;
    localparam int MOD = 256;

    logic          clkin;
    logic          resetn;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_chan;
    logic [AW-1:0] cfg_inc;
    logic [CH-1:0] ce_out;
    logic [CH-1:0] clk_out;
    logic          lock;

    int tests = 0;
    int fails = 0;

    frac_clk_gen #(
        .CHANNELS     (CH),
        .ACC_W        (AW),
        .INIT_INC     ({8'd37, 8'd0, 8'd64}),
        .SETTLE_CYCLES(S)
    ) dut (
        .clkin    (clkin),
        .resetn   (resetn),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_inc  (cfg_inc),
        .ce_out   (ce_out),
        .clk_out  (clk_out),
        .lock     (lock)
    );

    initial begin
        clkin = 0;
        forever #5 clkin = ~clkin;
    end

    // Reference model: phase per channel, one request slot, edge timestamps for lock.
    int m_phase [CH];
    int m_inc   [CH];
    bit m_ce    [CH];
    bit m_pend;
    int m_pchan;
    int m_pinc;
    int m_edge;
    int m_last;

    function automatic void model_reset();
        m_inc[0] = 64;
        m_inc[1] = 0;
        m_inc[2] = 37;
        for (int c = 0; c < CH; c++) begin
            m_phase[c] = 0;
            m_ce[c]    = 0;
        end
        m_pend = 0;
        m_edge = 0;
        m_last = 0;
    endfunction

    function automatic void model_step(input bit v, input int ch, input int inc);
        bit old_pend = m_pend;
        bit applied  = 0;
        m_edge++;
        for (int c = 0; c < CH; c++) begin
            int total = m_phase[c] + m_inc[c];
            bit carry = total >= MOD;
            m_ce[c] = carry;
            if (old_pend && m_pchan == c && (m_inc[c] == 0 || carry)) begin
                applied    = 1;
                m_inc[c]   = m_pinc;
                m_phase[c] = (m_pinc == 0) ? 0 : total % MOD;
            end else begin
                m_phase[c] = total % MOD;
            end
        end
        if (applied) begin
            m_pend = 0;
            m_last = m_edge;
        end else if (v && !old_pend && ch < CH) begin
            m_pend  = 1;
            m_pchan = ch;
            m_pinc  = inc;
        end
    endfunction

    function automatic logic [CH-1:0] mdl_ce();
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = m_ce[c];
        return r;
    endfunction

    function automatic logic [CH-1:0] mdl_clk();
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = (m_phase[c] >= MOD / 2);
        return r;
    endfunction

    function automatic logic mdl_lock();
        return !m_pend && ((m_edge - m_last) >= S);
    endfunction

    // Drive one cycle of request inputs, advance the model at the edge, settle 1ns after.
    task automatic tick(input bit v, input int ch, input int inc);
        cfg_valid = v;
        cfg_chan  = ch[1:0];
        cfg_inc   = inc[7:0];
        @(posedge clkin);
        if (resetn) model_step(v, ch, inc);
        #1;
        cfg_valid = 0;
    endtask

    task automatic test_reset();
        resetn    = 0;
        cfg_valid = 0;
        cfg_chan  = 0;
        cfg_inc   = 0;
        repeat (3) @(posedge clkin);
        #1;
        tests++;
        if (ce_out !== 3'b000 || clk_out !== 3'b000 || lock !== 1'b0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: ce=%b clk=%b lock=%b rdy=%b, want 000 000 0 1",
                     ce_out, clk_out, lock, cfg_ready);
        end
        resetn = 1;
        model_reset();
        for (int k = 1; k <= 16; k++) begin
            tick(0, 0, 0);
            tests++;
            if (ce_out[0] !== (k % 4 == 0) || clk_out[0] !== (k % 4 >= 2) || lock !== (k >= S)) begin
                fails++;
                $display("FAIL rate64 edge %0d: ce0=%b clk0=%b lock=%b, want %b %b %b", k,
                         ce_out[0], clk_out[0], lock, k % 4 == 0, k % 4 >= 2, k >= S);
            end
            tests++;
            if (ce_out !== mdl_ce() || clk_out !== mdl_clk()) begin
                fails++;
                $display("FAIL reset_model edge %0d: ce=%b clk=%b, want %b %b", k,
                         ce_out, clk_out, mdl_ce(), mdl_clk());
            end
        end
    endtask

    task automatic test_changeover();
        int  last_pulse = m_edge;
        int  apply_edge = -1;
        tick(0, 0, 0);
        tick(1, 0, 128);
        tests++;
        if (cfg_ready !== 1'b0 || lock !== 1'b0) begin
            fails++;
            $display("FAIL chg_accept: rdy=%b lock=%b, want 0 0", cfg_ready, lock);
        end
        for (int k = 0; k < 20; k++) begin
            tick(0, 0, 0);
            if (apply_edge < 0 && cfg_ready === 1'b1) begin
                apply_edge = m_edge;
                tests++;
                if (ce_out[0] !== 1'b1) begin
                    fails++;
                    $display("FAIL chg_at_carry: ce0=%b, want 1", ce_out[0]);
                end
            end
            if (ce_out[0] === 1'b1) begin
                tests++;
                if (m_edge - last_pulse < 2 || m_edge - last_pulse > 4 ||
                    (apply_edge >= 0 && m_edge > apply_edge && m_edge - last_pulse != 2)) begin
                    fails++;
                    $display("FAIL chg_gap at edge %0d: gap=%0d, want 2..4 (2 after change)",
                             m_edge, m_edge - last_pulse);
                end
                last_pulse = m_edge;
            end
            tests++;
            if (ce_out !== mdl_ce() || clk_out !== mdl_clk() || lock !== mdl_lock() ||
                cfg_ready !== !m_pend) begin
                fails++;
                $display("FAIL chg_model: ce=%b clk=%b lock=%b rdy=%b, want %b %b %b %b",
                         ce_out, clk_out, lock, cfg_ready, mdl_ce(), mdl_clk(), mdl_lock(), !m_pend);
            end
        end
        tests++;
        if (apply_edge < 0) begin
            fails++;
            $display("FAIL chg_applied: rdy=%b after 20 cycles, want 1", cfg_ready);
        end
    endtask

    task automatic test_enable();
        int apply_edge;
        int first = -1;
        tick(1, 1, 32);
        tests++;
        if (cfg_ready !== 1'b0 || lock !== 1'b0) begin
            fails++;
            $display("FAIL en_accept: rdy=%b lock=%b, want 0 0", cfg_ready, lock);
        end
        tick(0, 0, 0);
        apply_edge = m_edge;
        tests++;
        if (cfg_ready !== 1'b1 || ce_out[1] !== 1'b0) begin
            fails++;
            $display("FAIL en_apply: rdy=%b ce1=%b, want 1 0", cfg_ready, ce_out[1]);
        end
        for (int k = 1; k <= 20; k++) begin
            tick(0, 0, 0);
            if (first < 0 && ce_out[1] === 1'b1) first = k;
            tests++;
            if (lock !== (k >= S) || ce_out !== mdl_ce() || clk_out !== mdl_clk()) begin
                fails++;
                $display("FAIL en_cycle %0d: lock=%b ce=%b clk=%b, want %b %b %b", k,
                         lock, ce_out, clk_out, k >= S, mdl_ce(), mdl_clk());
            end
        end
        tests++;
        if (first != 8) begin
            fails++;
            $display("FAIL en_first_pulse: %0d cycles after apply at edge %0d, want 8",
                     first, apply_edge);
        end
    endtask

    task automatic test_drop();
        int guard = 0;
        while (lock !== 1'b1 && guard < 40) begin
            tick(0, 0, 0);
            guard++;
        end
        tick(1, 3, 99);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (cfg_ready !== 1'b1 || lock !== 1'b1 || ce_out !== mdl_ce() || clk_out !== mdl_clk()) begin
                fails++;
                $display("FAIL drop cycle %0d: rdy=%b lock=%b ce=%b clk=%b, want 1 1 %b %b", k,
                         cfg_ready, lock, ce_out, clk_out, mdl_ce(), mdl_clk());
            end
            tick(0, 0, 0);
        end
    endtask

    task automatic test_rate96();
        int guard = 0;
        int total = 0;
        int block = 0;
        tick(1, 0, 96);
        while (cfg_ready !== 1'b1 && guard < 10) begin
            tick(0, 0, 0);
            guard++;
        end
        tests++;
        if (cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL r96_apply: rdy=%b, want 1", cfg_ready);
        end
        for (int k = 1; k <= 256; k++) begin
            tick(0, 0, 0);
            if (ce_out[0] === 1'b1) begin
                total++;
                block++;
            end
            if (k % 8 == 0) begin
                tests++;
                if (block != 3) begin
                    fails++;
                    $display("FAIL r96_block %0d: %0d pulses, want 3", k / 8, block);
                end
                block = 0;
            end
            tests++;
            if (ce_out !== mdl_ce() || clk_out !== mdl_clk() || lock !== mdl_lock()) begin
                fails++;
                $display("FAIL r96_model %0d: ce=%b clk=%b lock=%b, want %b %b %b", k,
                         ce_out, clk_out, lock, mdl_ce(), mdl_clk(), mdl_lock());
            end
        end
        tests++;
        if (total != 96) begin
            fails++;
            $display("FAIL r96_total: %0d pulses, want 96", total);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            bit v   = ($urandom_range(0, 3) == 0);
            int ch  = $urandom_range(0, 3);
            int sel = $urandom_range(0, 7);
            int inc = (sel == 0) ? 0 : (sel == 1) ? 128 : (sel == 2) ? 255 : $urandom_range(1, 255);
            tick(v, ch, inc);
            tests++;
            if (ce_out !== mdl_ce() || clk_out !== mdl_clk() || lock !== mdl_lock() ||
                cfg_ready !== !m_pend) begin
                fails++;
                $display("FAIL rand %0d: ce=%b clk=%b lock=%b rdy=%b, want %b %b %b %b", k,
                         ce_out, clk_out, lock, cfg_ready, mdl_ce(), mdl_clk(), mdl_lock(), !m_pend);
            end
        end
    endtask

    task automatic test_reset_pending();
        int guard = 0;
        while (cfg_ready !== 1'b1 && guard < 600) begin
            tick(0, 0, 0);
            guard++;
        end
        tick(1, 0, 200);
        tests++;
        if (cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL rstp_pending: rdy=%b, want 0", cfg_ready);
        end
        resetn = 0;
        #2;
        tests++;
        if (ce_out !== 3'b000 || clk_out !== 3'b000 || lock !== 1'b0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstp_state: ce=%b clk=%b lock=%b rdy=%b, want 000 000 0 1",
                     ce_out, clk_out, lock, cfg_ready);
        end
        @(posedge clkin);
        @(posedge clkin);
        #1;
        resetn = 1;
        model_reset();
        for (int k = 1; k <= 24; k++) begin
            tick(0, 0, 0);
            tests++;
            if (ce_out[0] !== (k % 4 == 0) || ce_out[1] !== 1'b0 || lock !== (k >= S) ||
                ce_out !== mdl_ce() || clk_out !== mdl_clk() || cfg_ready !== 1'b1) begin
                fails++;
                $display("FAIL rstp_resume %0d: ce=%b clk=%b lock=%b rdy=%b, want %b %b %b 1", k,
                         ce_out, clk_out, lock, cfg_ready, mdl_ce(), mdl_clk(), k >= S);
            end
        end
    endtask

    initial begin
        test_reset();
        test_changeover();
        test_enable();
        test_drop();
        test_rate96();
        test_random();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
